// File: rtl/riscv_imem_if.sv
// Fetch request/response channel between the fetch front end and the instruction memory.
interface riscv_imem_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_inst;
  logic        rsp_fault;

  modport slave  (input  req_valid, req_addr, rsp_ready,
                  output req_ready, rsp_valid, rsp_inst, rsp_fault);
  modport master (output req_valid, req_addr, rsp_ready,
                  input  req_ready, rsp_valid, rsp_inst, rsp_fault);
endinterface

// File: rtl/riscv_imem_responder.sv
// Instruction memory with in-order, fixed-latency fetch responses and a byte-serial boot loader.
module riscv_imem_responder #(
  parameter int          DEPTH_LOG2 = 10,
  parameter int          LATENCY    = 1,
  parameter logic [31:0] NOP_INST   = 32'h00000013
) (
  input  logic                  clk,
  input  logic                  reset,
  riscv_imem_if.slave           fetch,
  input  logic                  ld_start,
  input  logic                  ld_valid,
  input  logic [7:0]            ld_byte,
  input  logic                  ld_last,
  output logic [DEPTH_LOG2:0]   ld_words,
  output logic                  busy
);
  localparam int DEPTH  = 2**DEPTH_LOG2;
  localparam int FDEPTH = LATENCY + 1;
  localparam int CW     = $clog2(FDEPTH + 1);
  localparam int PW     = $clog2(FDEPTH);
  localparam int LW     = DEPTH_LOG2 + 1;

  typedef struct packed {
    logic        fault;
    logic [31:0] inst;
  } rsp_t;

  typedef enum logic [1:0] {RUN, DRAIN, LOAD} state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   outstanding, out_nxt;
  logic            acc, consume;
  logic [31:0]     mem [DEPTH];

  assign fetch.req_ready = (state == RUN) && !ld_start && (outstanding < CW'(FDEPTH));
  assign acc     = fetch.req_valid && fetch.req_ready;
  assign consume = fetch.rsp_valid && fetch.rsp_ready;
  assign out_nxt = outstanding + CW'(acc) - CW'(consume);
  assign busy    = (state != RUN);

  always_comb begin
    state_nxt = state;
    unique case (state)
      RUN:     if (ld_start) state_nxt = (out_nxt == '0) ? LOAD : DRAIN;
      DRAIN:   if (outstanding == '0) state_nxt = LOAD;
      LOAD:    if (ld_valid && ld_last) state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= RUN;
      outstanding <= '0;
    end else begin
      state       <= state_nxt;
      outstanding <= out_nxt;
    end
  end

  // Read pipeline: stage 1 holds the memory read (or NOP for faults); no stalls needed
  // because the FIFO behind it always has room for everything outstanding.
  logic [DEPTH_LOG2-1:0] ridx;
  logic                  req_fault;
  logic [LATENCY:1]      vld_pipe;
  rsp_t                  pipe [1:LATENCY];

  assign ridx      = fetch.req_addr[DEPTH_LOG2+1:2];
  assign req_fault = (|fetch.req_addr[1:0]) || (|fetch.req_addr[31:DEPTH_LOG2+2]);

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_pipe <= '0;
      for (int i = 1; i <= LATENCY; i++) pipe[i] <= '0;
    end else begin
      vld_pipe[1] <= acc;
      if (acc) pipe[1] <= {req_fault, req_fault ? NOP_INST : mem[ridx]};
      for (int i = 2; i <= LATENCY; i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
        pipe[i]     <= pipe[i-1];
      end
    end
  end

  // Response FIFO with bypass: the pipeline tail is presented directly when the FIFO
  // is empty, and is parked in the FIFO whenever it cannot be consumed this cycle.
  rsp_t          fifo [FDEPTH];
  rsp_t          rsp_head;
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] cnt;
  logic          fifo_empty, push, pop;

  assign fifo_empty      = (cnt == '0);
  assign push            = vld_pipe[LATENCY] && !(fifo_empty && fetch.rsp_ready);
  assign pop             = !fifo_empty && fetch.rsp_ready;
  assign rsp_head        = fifo_empty ? pipe[LATENCY] : fifo[rd_ptr];
  assign fetch.rsp_valid = fifo_empty ? vld_pipe[LATENCY] : 1'b1;
  assign fetch.rsp_inst  = rsp_head.inst;
  assign fetch.rsp_fault = rsp_head.fault;

  always_ff @(posedge clk) begin
    if (push) fifo[wr_ptr] <= pipe[LATENCY];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= (wr_ptr == PW'(FDEPTH-1)) ? '0 : wr_ptr + 1'b1;
      if (pop)  rd_ptr <= (rd_ptr == PW'(FDEPTH-1)) ? '0 : rd_ptr + 1'b1;
      cnt <= cnt + CW'(push) - CW'(pop);
    end
  end

  // Loader: ld_words doubles as the write pointer; it stops at DEPTH so later words drop.
  logic [1:0]  ld_idx;
  logic [23:0] ld_buf;
  logic [31:0] ld_word;
  logic        ld_fire, ld_wr;

  assign ld_fire = (state == LOAD) && ld_valid;
  assign ld_wr   = ld_fire && ((ld_idx == 2'd3) || ld_last);

  always_comb begin
    ld_word = {8'h00, ld_buf};
    ld_word[{ld_idx, 3'b000} +: 8] = ld_byte;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ld_idx   <= '0;
      ld_buf   <= '0;
      ld_words <= '0;
    end else if (state != LOAD && state_nxt == LOAD) begin
      ld_idx   <= '0;
      ld_buf   <= '0;
      ld_words <= '0;
    end else if (ld_fire) begin
      if (ld_wr) begin
        ld_idx <= '0;
        ld_buf <= '0;
        if (ld_words < LW'(DEPTH)) ld_words <= ld_words + 1'b1;
      end else begin
        ld_idx <= ld_idx + 1'b1;
        ld_buf <= ld_word[23:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && ld_wr && ld_words < LW'(DEPTH))
      mem[ld_words[DEPTH_LOG2-1:0]] <= ld_word;
  end
endmodule
